// File: rtl/modmul_pre_multiplier.sv
// ---------------------------------------------------------------------------
// modmul_pre_multiplier
//
// Pipelined integer multiplier that feeds barrett_pipelined. It computes
// x = a*b and flags operand pairs that fall outside [0,q). Barrett reduction
// needs x < q^2, so an out-of-range operand makes the downstream result
// meaningless. Such a product is still computed and emitted; it is only
// flagged.
//
// Each operand is split into hi/lo halves. S1 registers the operands and the
// range flag. S2 registers the four half-width partial products. S3
// recombines them into x_o. One operand pair is accepted per cycle.
//
// Handshake: start_i is a valid-only strobe. There is no ready, because the
// downstream Barrett stage cannot stall, so every cycle with start_i=1 (and
// rst_i=0) is an accepted transaction. valid_o is a one-cycle pulse per
// result. Results leave in issue order three register stages after the edge
// that sampled start_i.
//
// Ports
//   CLK_pci_sys_clk_p  in   1           rising-edge clock
//   rst_i              in   1           synchronous reset, active-high
//   start_i            in   1           a_i/b_i valid this cycle
//   a_i, b_i           in   OP_WIDTH    operands
//   q_i                in   OP_WIDTH    modulus, used only for the range check
//   x_o                out  2*OP_WIDTH  product a*b (held while valid_o=0)
//   valid_o            out  1           x_o/range_err_o valid this cycle
//   range_err_o        out  1           a>=q or b>=q for this result
//   busy_o             out  1           any pipeline stage holds an item
//   count_o            out  CNT_WIDTH   results emitted since reset (wraps)
// ---------------------------------------------------------------------------
module modmul_pre_multiplier #(
    parameter int OP_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  CLK_pci_sys_clk_p,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [OP_WIDTH-1:0]   a_i,
    input  logic [OP_WIDTH-1:0]   b_i,
    input  logic [OP_WIDTH-1:0]   q_i,
    output logic [2*OP_WIDTH-1:0] x_o,
    output logic                  valid_o,
    output logic                  range_err_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    localparam int HALF_WIDTH = OP_WIDTH / 2;
    localparam int PP_WIDTH   = 2 * HALF_WIDTH;
    localparam int MID_WIDTH  = PP_WIDTH + 1;
    localparam int X_WIDTH    = 2 * OP_WIDTH;

    // ---------------- S1: operand register ----------------
    logic                s1_valid;
    logic                s1_err;
    logic [OP_WIDTH-1:0] s1_a;
    logic [OP_WIDTH-1:0] s1_b;

    always_ff @(posedge CLK_pci_sys_clk_p) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= start_i;
            if (start_i) begin
                s1_a   <= a_i;
                s1_b   <= b_i;
                s1_err <= (a_i >= q_i) | (b_i >= q_i);
            end
        end
    end

    logic [HALF_WIDTH-1:0] a_lo, a_hi, b_lo, b_hi;
    assign a_lo = s1_a[HALF_WIDTH-1:0];
    assign a_hi = s1_a[OP_WIDTH-1:HALF_WIDTH];
    assign b_lo = s1_b[HALF_WIDTH-1:0];
    assign b_hi = s1_b[OP_WIDTH-1:HALF_WIDTH];

    // ---------------- S2: partial products ----------------
    logic                s2_valid;
    logic                s2_err;
    logic [PP_WIDTH-1:0] p_ll, p_lh, p_hl, p_hh;

    always_ff @(posedge CLK_pci_sys_clk_p) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            p_ll     <= '0;
            p_lh     <= '0;
            p_hl     <= '0;
            p_hh     <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_err <= s1_err;
                p_ll   <= PP_WIDTH'(a_lo * b_lo);
                p_lh   <= PP_WIDTH'(a_lo * b_hi);
                p_hl   <= PP_WIDTH'(a_hi * b_lo);
                p_hh   <= PP_WIDTH'(a_hi * b_hi);
            end
        end
    end

    // ---------------- S3: recombination ----------------
    // The middle sum carries one extra bit. Dropping it would corrupt
    // products whose cross terms are both large, for example all-ones
    // operands. p_hh and p_ll do not overlap, so they are concatenated
    // rather than added.
    logic [MID_WIDTH-1:0] mid_sum;
    logic [X_WIDTH-1:0]   mid_ext;
    logic [X_WIDTH-1:0]   x_next;

    assign mid_sum = {1'b0, p_lh} + {1'b0, p_hl};
    assign mid_ext = {{(X_WIDTH-MID_WIDTH){1'b0}}, mid_sum} << HALF_WIDTH;
    assign x_next  = {p_hh, p_ll} + mid_ext;

    logic s3_valid;

    always_ff @(posedge CLK_pci_sys_clk_p) begin
        if (rst_i) begin
            s3_valid    <= 1'b0;
            x_o         <= '0;
            range_err_o <= 1'b0;
            count_o     <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                // x_o and range_err_o hold their values between results.
                x_o         <= x_next;
                range_err_o <= s2_err;
                // Counting on the load edge keeps count_o in step with valid_o.
                count_o     <= count_o + 1'b1;
            end
        end
    end

    assign valid_o = s3_valid;

    // Derived only from stage flops; start_i has no combinational path here.
    assign busy_o = s1_valid | s2_valid | s3_valid;

endmodule

// File: tb/tb_modmul_pre_multiplier.sv
module tb_modmul_pre_multiplier;

  localparam int OP_WIDTH  = 32;
  localparam int CNT_WIDTH = 16;
  localparam int XW        = 2 * OP_WIDTH;
  localparam logic [31:0] Q_DIL = 32'd8380417;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [OP_WIDTH-1:0]  a = '0;
  logic [OP_WIDTH-1:0]  b = '0;
  logic [OP_WIDTH-1:0]  q = '0;
  logic [XW-1:0]        x_o;
  logic                 valid_o;
  logic                 range_err_o;
  logic                 busy_o;
  logic [CNT_WIDTH-1:0] count_o;

  always #5 clk = ~clk;

  modmul_pre_multiplier #(.OP_WIDTH(OP_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .CLK_pci_sys_clk_p (clk),
    .rst_i             (rst),
    .start_i           (start),
    .a_i               (a),
    .b_i               (b),
    .q_i               (q),
    .x_o               (x_o),
    .valid_o           (valid_o),
    .range_err_o       (range_err_o),
    .busy_o            (busy_o),
    .count_o           (count_o)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {range_err, x}.
  logic [XW:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every presented result against the queue head.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      logic [XW:0] e;
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got x=0x%0h, expected no result", x_o);
      end else begin
        e = exp_q.pop_front();
        check("x_o", x_o, e[XW-1:0]);
        check("range_err_o", {{(XW-1){1'b0}}, range_err_o}, {{(XW-1){1'b0}}, e[XW]});
      end
    end
  end

  // ---------------- driver tasks (all called at a negedge) ----------------
  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tq,
                      input logic [XW-1:0] ex, input logic eerr, input bit expect_out);
    start = 1'b1;
    a = ta;
    b = tb;
    q = tq;
    if (expect_out) exp_q.push_back({eerr, ex});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int v_before;
    logic [31:0] ta, tb;

    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_valid", {63'd0, valid_o}, '0);
    check("rst_busy", {63'd0, busy_o}, '0);
    check("rst_count", {48'd0, count_o}, '0);
    check("rst_x", x_o, '0);
    check("rst_err", {63'd0, range_err_o}, '0);

    // 1: small product, latency and count
    send(32'd3, 32'd5, Q_DIL, 64'd15, 1'b0, 1'b1);
    start = 1'b0;
    lat = 1;
    while (!valid_o && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd3);
    check("count_after_1", {48'd0, count_o}, 64'd1);
    idle(2);

    // 2: (q-1)^2
    send(32'd8380416, 32'd8380416, Q_DIL, 64'h00003FE004000000, 1'b0, 1'b1);
    idle(1);
    drain();

    // 3: eight back-to-back starts after a fresh reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ta = 32'(i + 1);
      tb = 32'(i + 2);
      send(ta, tb, Q_DIL, 64'((i + 1) * (i + 2)), 1'b0, 1'b1);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_last_stage", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    check("busy_dropped", {63'd0, busy_o}, 64'd0);
    check("count_after_8", {48'd0, count_o}, 64'd8);
    drain();

    // 4: out-of-range operand still emits product, flag clears on next item
    send(Q_DIL, 32'd1, Q_DIL, 64'd8380417, 1'b1, 1'b1);
    send(32'd1, 32'd1, Q_DIL, 64'd1, 1'b0, 1'b1);
    idle(1);
    drain();
    idle(1);
    check("x_held", x_o, 64'd1);

    // 6: all-ones operands exercise the middle-sum carry
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1, 1'b1);
    idle(1);
    drain();
    idle(2);

    // 5: reset with items in flight, plus a start coinciding with reset
    v_before = n_valid;
    send(32'd7, 32'd9, Q_DIL, '0, 1'b0, 1'b0);
    send(32'd11, 32'd13, Q_DIL, '0, 1'b0, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    a = 32'd2;
    b = 32'd2;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    idle(6);
    check("flush_no_valid", 64'(n_valid - v_before), 64'd0);
    check("flush_busy", {63'd0, busy_o}, 64'd0);
    check("flush_count", {48'd0, count_o}, 64'd0);
    check("flush_x", x_o, 64'd0);
    check("flush_err", {63'd0, range_err_o}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
